// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the MEM stage and MEM/WB pipeline register.
package mem_wb_stage_pkg;

  localparam int WORD_W = 32;

  // Write-back source select encoding carried in MemtoReg.
  localparam logic MEMTOREG_ALU = 1'b0;
  localparam logic MEMTOREG_MEM = 1'b1;

  // A word access is misaligned when the byte offset inside the word is non-zero.
  function automatic logic isMisaligned(input logic [1:0] byteOffset);
    return byteOffset != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_stage_data_memory.sv
// Word-organised data memory: combinational read, synchronous write.
module data_memory
  import mem_wb_stage_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              writeEnable,
  input  logic [ADDR_W-1:0] wordAddr,
  input  logic [WORD_W-1:0] writeData,
  output logic [WORD_W-1:0] readData
);

  logic [WORD_W-1:0] memArray [DEPTH];

  // Asynchronous read so the MEM-stage result is ready for the WB register edge.
  assign readData = memArray[wordAddr];

  // Single write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (writeEnable) begin
      memArray[wordAddr] <= writeData;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage data access plus the MEM/WB pipeline register.
// The store data can be forwarded from the instruction currently in WB so a
// load followed directly by a dependent store needs no stall.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic              MEM_RegWrite,
  input  logic              MEM_MemtoReg,
  input  logic [WORD_W-1:0] MEM_ALUResult,
  input  logic [WORD_W-1:0] MEM_WriteData,
  input  logic [4:0]        MEM_WriteRegister,
  input  logic              Memoryforwarding,
  input  logic              Stall,
  input  logic              Flush,
  output logic              WB_RegWrite,
  output logic              WB_MemtoReg,
  output logic              WB_MemRead,
  output logic [4:0]        WB_WriteRegister,
  output logic [WORD_W-1:0] WB_ReadData,
  output logic [WORD_W-1:0] WB_ALUResult,
  output logic [WORD_W-1:0] WB_WriteBackData,
  output logic              MisalignedAccess
);

  logic [ADDR_W-1:0] wordAddr;
  logic              offsetBad;
  logic              accessMisaligned;
  logic [WORD_W-1:0] storeData;
  logic              memWriteEn;
  logic [WORD_W-1:0] readWord;

  // Upper address bits above the array size are ignored, so accesses wrap.
  assign wordAddr         = MEM_ALUResult[ADDR_W+1:2];
  assign offsetBad        = isMisaligned(MEM_ALUResult[1:0]);
  assign accessMisaligned = (MEM_MemRead | MEM_MemWrite) & offsetBad;

  // Load-to-store forwarding: take the value being written back this cycle.
  assign storeData = Memoryforwarding ? WB_WriteBackData : MEM_WriteData;

  // rst_n gates the write so an edge seen during reset never commits a store.
  assign memWriteEn = MEM_MemWrite & ~Stall & ~Flush & ~offsetBad & rst_n;

  data_memory #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) uDataMemory (
    .clk        (clk),
    .writeEnable(memWriteEn),
    .wordAddr   (wordAddr),
    .writeData  (storeData),
    .readData   (readWord)
  );

  // ---- MEM -> WB boundary ----
  // Flush inserts a bubble (control cleared), Stall holds, otherwise advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_RegWrite      <= 1'b0;
      WB_MemtoReg      <= MEMTOREG_ALU;
      WB_MemRead       <= 1'b0;
      MisalignedAccess <= 1'b0;
      WB_WriteRegister <= '0;
      WB_ReadData      <= '0;
      WB_ALUResult     <= '0;
    end else if (Flush) begin
      WB_RegWrite      <= 1'b0;
      WB_MemtoReg      <= MEMTOREG_ALU;
      WB_MemRead       <= 1'b0;
      MisalignedAccess <= 1'b0;
      WB_WriteRegister <= MEM_WriteRegister;
      WB_ReadData      <= readWord;
      WB_ALUResult     <= MEM_ALUResult;
    end else if (!Stall) begin
      WB_RegWrite      <= MEM_RegWrite;
      WB_MemtoReg      <= MEM_MemtoReg;
      WB_MemRead       <= MEM_MemRead;
      MisalignedAccess <= accessMisaligned;
      WB_WriteRegister <= MEM_WriteRegister;
      WB_ReadData      <= readWord;
      WB_ALUResult     <= MEM_ALUResult;
    end
  end

  // ---- WB stage ----
  assign WB_WriteBackData = (WB_MemtoReg == MEMTOREG_MEM) ? WB_ReadData : WB_ALUResult;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a behavioural model predicts the WB
// register contents for every driven cycle and queues them for comparison.
module tb_mem_wb_stage;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MEM_MemRead, MEM_MemWrite, MEM_RegWrite, MEM_MemtoReg;
  logic [31:0] MEM_ALUResult, MEM_WriteData;
  logic [4:0]  MEM_WriteRegister;
  logic        Memoryforwarding, Stall, Flush;
  logic        WB_RegWrite, WB_MemtoReg, WB_MemRead, MisalignedAccess;
  logic [4:0]  WB_WriteRegister;
  logic [31:0] WB_ReadData, WB_ALUResult, WB_WriteBackData;

  mem_wb_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .MEM_MemRead      (MEM_MemRead),
    .MEM_MemWrite     (MEM_MemWrite),
    .MEM_RegWrite     (MEM_RegWrite),
    .MEM_MemtoReg     (MEM_MemtoReg),
    .MEM_ALUResult    (MEM_ALUResult),
    .MEM_WriteData    (MEM_WriteData),
    .MEM_WriteRegister(MEM_WriteRegister),
    .Memoryforwarding (Memoryforwarding),
    .Stall            (Stall),
    .Flush            (Flush),
    .WB_RegWrite      (WB_RegWrite),
    .WB_MemtoReg      (WB_MemtoReg),
    .WB_MemRead       (WB_MemRead),
    .WB_WriteRegister (WB_WriteRegister),
    .WB_ReadData      (WB_ReadData),
    .WB_ALUResult     (WB_ALUResult),
    .WB_WriteBackData (WB_WriteBackData),
    .MisalignedAccess (MisalignedAccess)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        regWrite;
    bit        memtoReg;
    bit        memRead;
    bit        mis;
    bit [4:0]  wreg;
    bit [31:0] rd;
    bit [31:0] alu;
    bit        rdKnown;
    bit        aluKnown;
  } wbExp_t;

  wbExp_t    mdl;
  wbExp_t    expQ[$];
  bit [31:0] refMem [DEPTH];
  bit        memKnown [DEPTH];
  int        nTests = 0;
  int        nFail  = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] mdlWbData(input wbExp_t e);
    return e.memtoReg ? e.rd : e.alu;
  endfunction

  function automatic bit mdlWbKnown(input wbExp_t e);
    return e.memtoReg ? e.rdKnown : e.aluKnown;
  endfunction

  task automatic resetModel();
    mdl = '{default: 0};
    mdl.rdKnown  = 1'b1;
    mdl.aluKnown = 1'b1;
    expQ.delete();
  endtask

  task automatic compareOut(input string tag);
    wbExp_t e;
    if (expQ.size() == 0) begin
      checkVal({tag, "/queue"}, 32'd0, 32'd1);
      return;
    end
    e = expQ.pop_front();
    checkVal({tag, "/RegWrite"}, {31'd0, WB_RegWrite}, {31'd0, e.regWrite});
    checkVal({tag, "/MemtoReg"}, {31'd0, WB_MemtoReg}, {31'd0, e.memtoReg});
    checkVal({tag, "/MemRead"},  {31'd0, WB_MemRead},  {31'd0, e.memRead});
    checkVal({tag, "/Misalign"}, {31'd0, MisalignedAccess}, {31'd0, e.mis});
    if (e.regWrite) checkVal({tag, "/WriteReg"}, {27'd0, WB_WriteRegister}, {27'd0, e.wreg});
    if (e.aluKnown) checkVal({tag, "/ALUResult"}, WB_ALUResult, e.alu);
    if (e.rdKnown)  checkVal({tag, "/ReadData"}, WB_ReadData, e.rd);
    if (mdlWbKnown(e)) checkVal({tag, "/WBData"}, WB_WriteBackData, mdlWbData(e));
  endtask

  // Drive one MEM-stage cycle, predict the WB state after the edge, then compare.
  task automatic drive(input string tag, input bit rd, input bit wr, input bit rw, input bit m2r,
                       input bit [31:0] addr, input bit [31:0] wdata, input bit [4:0] wreg,
                       input bit fwd, input bit stall, input bit flush);
    bit [ADDR_W-1:0] idx;
    bit [31:0]       sdata;
    bit              sKnown;
    bit              mis;
    wbExp_t          nxt;
    idx    = addr[ADDR_W+1:2];
    mis    = (addr[1:0] != 2'b00);
    sdata  = fwd ? mdlWbData(mdl) : wdata;
    sKnown = fwd ? mdlWbKnown(mdl) : 1'b1;
    nxt    = mdl;
    if (flush) begin
      nxt.regWrite = 0; nxt.memtoReg = 0; nxt.memRead = 0; nxt.mis = 0;
      nxt.rdKnown = 0; nxt.aluKnown = 0;
    end else if (!stall) begin
      nxt.regWrite = rw; nxt.memtoReg = m2r; nxt.memRead = rd;
      nxt.mis      = (rd || wr) && mis;
      nxt.wreg     = wreg;
      nxt.alu      = addr; nxt.aluKnown = 1'b1;
      nxt.rd       = refMem[idx]; nxt.rdKnown = memKnown[idx];
    end
    if (wr && !stall && !flush && !mis) begin
      refMem[idx]   = sdata;
      memKnown[idx] = sKnown;
    end
    mdl = nxt;
    expQ.push_back(nxt);
    MEM_MemRead = rd; MEM_MemWrite = wr; MEM_RegWrite = rw; MEM_MemtoReg = m2r;
    MEM_ALUResult = addr; MEM_WriteData = wdata; MEM_WriteRegister = wreg;
    Memoryforwarding = fwd; Stall = stall; Flush = flush;
    @(posedge clk);
    #1;
    compareOut(tag);
  endtask

  task automatic idle(input string tag);
    drive(tag, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
  endtask

  task automatic store(input string tag, input bit [31:0] addr, input bit [31:0] data);
    drive(tag, 0, 1, 0, 0, addr, data, 5'd0, 0, 0, 0);
  endtask

  task automatic load(input string tag, input bit [31:0] addr, input bit [4:0] reg_n);
    drive(tag, 1, 0, 1, 1, addr, 32'h0, reg_n, 0, 0, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "/RegWrite"}, {31'd0, WB_RegWrite}, 32'd0);
    checkVal({tag, "/MemtoReg"}, {31'd0, WB_MemtoReg}, 32'd0);
    checkVal({tag, "/MemRead"},  {31'd0, WB_MemRead},  32'd0);
    checkVal({tag, "/Misalign"}, {31'd0, MisalignedAccess}, 32'd0);
    checkVal({tag, "/WriteReg"}, {27'd0, WB_WriteRegister}, 32'd0);
    checkVal({tag, "/ReadData"}, WB_ReadData, 32'd0);
    checkVal({tag, "/ALUResult"}, WB_ALUResult, 32'd0);
    checkVal({tag, "/WBData"}, WB_WriteBackData, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      refMem[i] = '0; memKnown[i] = 1'b0;
    end
    rst_n = 1'b0;
    MEM_MemRead = 0; MEM_MemWrite = 0; MEM_RegWrite = 0; MEM_MemtoReg = 0;
    MEM_ALUResult = '0; MEM_WriteData = '0; MEM_WriteRegister = '0;
    Memoryforwarding = 0; Stall = 0; Flush = 0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;

    // Store then load
    store("st10", 32'h10, 32'hDEADBEEF);
    load ("ld10", 32'h10, 5'd8);
    checkVal("ld10/direct", WB_WriteBackData, 32'hDEADBEEF);
    idle ("idle0");

    // Forwarded store: loaded value in WB is written by the next store
    store("st40", 32'h40, 32'h12345678);
    load ("ld40", 32'h40, 5'd9);
    drive("fwdst20", 0, 1, 0, 0, 32'h20, 32'h0, 5'd0, 1, 0, 0);
    load ("ld20", 32'h20, 5'd10);
    checkVal("ld20/direct", WB_ReadData, 32'h12345678);

    // Stall: store suppressed, WB held for every stalled cycle
    store("st30", 32'h30, 32'h11111111);
    load ("ld40b", 32'h40, 5'd11);
    for (int i = 0; i < 3; i++)
      drive("stall", 0, 1, 1, 0, 32'h30, 32'hAAAA5555, 5'd3, 0, 1, 0);
    load ("ld30a", 32'h30, 5'd12);
    checkVal("ld30a/direct", WB_ReadData, 32'h11111111);

    // Flush and Flush+Stall: bubble, no write
    drive("flush",  0, 1, 1, 0, 32'h30, 32'hAAAA5555, 5'd3, 0, 0, 1);
    load ("ld30b", 32'h30, 5'd13);
    drive("flushst", 0, 1, 1, 0, 32'h30, 32'hAAAA5555, 5'd3, 0, 1, 1);
    load ("ld30c", 32'h30, 5'd14);
    checkVal("ld30c/direct", WB_ReadData, 32'h11111111);

    // Misaligned store, then misaligned load returning the aligned word
    drive("mis33", 0, 1, 1, 0, 32'h33, 32'h00000BAD, 5'd4, 0, 0, 0);
    checkVal("mis33/flag", {31'd0, MisalignedAccess}, 32'd1);
    idle ("misclr");
    checkVal("misclr/flag", {31'd0, MisalignedAccess}, 32'd0);
    load ("ld31", 32'h31, 5'd15);
    checkVal("ld31/direct", WB_ReadData, 32'h11111111);

    // Address wrap modulo DEPTH
    store("stwrap", 32'(4 * DEPTH + 4), 32'h1);
    load ("ld04", 32'h4, 5'd16);
    checkVal("ld04/direct", WB_ReadData, 32'h1);

    // Mid-run asynchronous reset; a store seen at an edge during reset is dropped
    store("st50", 32'h50, 32'h00005050);
    load ("ld50", 32'h50, 5'd17);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    MEM_MemRead = 0; MEM_MemWrite = 1; MEM_RegWrite = 0; MEM_MemtoReg = 0;
    MEM_ALUResult = 32'h50; MEM_WriteData = 32'hFFFF0000;
    @(posedge clk);
    #1;
    resetModel();
    rst_n = 1'b1;
    idle ("postreset");
    checkVal("postreset/WBData", WB_WriteBackData, 32'd0);
    load ("ld50b", 32'h50, 5'd18);
    checkVal("ld50b/direct", WB_ReadData, 32'h00005050);

    // Random aligned store/load pairs
    for (int i = 0; i < 8; i++) begin
      bit [31:0] a;
      bit [31:0] d;
      a = {22'($urandom), 8'($urandom_range(0, 63)), 2'b00};
      d = $urandom;
      store("rndst", a, d);
      load ("rndld", a, 5'($urandom_range(1, 31)));
    end

    checkVal("queue/empty", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
